// File: rtl/chan_pkg.sv
// chan_pkg: shared widths, tuser field offsets and framer state type
package chan_pkg;
  localparam int DATA_W  = 32;
  localparam int BIN_W   = 11;
  localparam int SEQ_W   = 12;
  localparam int LEN_W   = 16;
  localparam int EOB_BIT = SEQ_W + BIN_W;
  localparam int SEQ_LSB = BIN_W;
  localparam int BIN_LSB = 0;
  typedef enum logic [1:0] {EMPTY, HOLD, FLUSH} fr_state_t;
endpackage

// File: rtl/chan_pkt_framer.sv
// chan_pkt_framer: cuts the bin-tagged channelizer stream into per-bin packets with {eob, seq, bin} sideband
module chan_pkt_framer
  import chan_pkg::*;
#(
  parameter int DATA_W = chan_pkg::DATA_W,
  parameter int BIN_W  = chan_pkg::BIN_W,
  parameter int SEQ_W  = chan_pkg::SEQ_W,
  parameter int LEN_W  = chan_pkg::LEN_W
) (
  input  logic                   ce_clk,
  input  logic                   ce_rst_n,
  input  logic [LEN_W-1:0]       pkt_words,
  input  logic                   flush_req,
  input  logic [DATA_W-1:0]      s_axis_tdata,
  input  logic [BIN_W-1:0]       s_axis_tuser,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [DATA_W-1:0]      m_axis_tdata,
  output logic [SEQ_W+BIN_W:0]   m_axis_tuser,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [31:0]            pkt_count
);
  fr_state_t state, state_n;
  logic [DATA_W-1:0] h_data;
  logic [BIN_W-1:0]  h_bin;
  logic [LEN_W-1:0]  word_cnt, plen, cur_plen;
  logic [SEQ_W-1:0]  seq;
  logic o_free, accept, move, last_n, eob_n;

  assign o_free        = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = state != FLUSH && (state == EMPTY || o_free);
  assign accept        = s_axis_tvalid && s_axis_tready;

  // lookahead tlast decision: the incoming sample decides whether H closes the packet
  always_comb begin
    cur_plen = word_cnt == '0 ? (pkt_words == '0 ? LEN_W'(1) : pkt_words) : plen;
    move     = state == FLUSH ? o_free : (state == HOLD && accept);
    eob_n    = state == FLUSH;
    last_n   = eob_n || word_cnt == cur_plen - 1'b1 || s_axis_tuser != h_bin;
    state_n  = state == EMPTY ? (accept ? (flush_req ? FLUSH : HOLD) : EMPTY) :
               state == HOLD  ? (flush_req ? FLUSH : HOLD) :
                                (o_free ? EMPTY : FLUSH);
  end

  // state register
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) state <= EMPTY;
    else           state <= state_n;
  end

  // hold register H takes every accepted sample
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      h_data <= '0;
      h_bin  <= '0;
    end else if (accept) begin
      h_data <= s_axis_tdata;
      h_bin  <= s_axis_tuser;
    end
  end

  // registered output stage O, held stable while stalled
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (move) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= h_data;
      m_axis_tuser  <= {eob_n, seq, h_bin};
      m_axis_tlast  <= last_n;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // word counter, latched packet length, sequence number and packet count
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      word_cnt  <= '0;
      plen      <= '0;
      seq       <= '0;
      pkt_count <= '0;
    end else if (move) begin
      if (word_cnt == '0) plen <= cur_plen;
      word_cnt  <= last_n ? '0 : word_cnt + 1'b1;
      seq       <= last_n ? seq + 1'b1 : seq;
      pkt_count <= last_n ? pkt_count + 1 : pkt_count;
    end
  end
endmodule

// File: tb/tb_chan_pkt_framer.sv
// tb_chan_pkt_framer: directed checks of packet cutting, sideband, flush, backpressure and reset
module tb_chan_pkt_framer;
  import chan_pkg::*;
  localparam int USER_W = SEQ_W + BIN_W + 1;

  logic              ce_clk = 1'b0;
  logic              ce_rst_n = 1'b0;
  logic [LEN_W-1:0]  pkt_words = '0;
  logic              flush_req = 1'b0;
  logic [DATA_W-1:0] s_axis_tdata = '0;
  logic [BIN_W-1:0]  s_axis_tuser = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic [USER_W-1:0] m_axis_tuser;
  logic              m_axis_tlast;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b0;
  logic [31:0]       pkt_count;

  int tests = 0;
  int fails = 0;
  int acc = 0;
  int emit = 0;
  int ph = 0;
  logic bp_on = 1'b0;
  logic stall = 1'b0;
  logic chk_stab = 1'b0;
  logic was_stall = 1'b0;
  logic [DATA_W-1:0] pd;
  logic [USER_W-1:0] pu;
  logic [DATA_W-1:0] od[$];
  logic [USER_W-1:0] ou[$];
  logic              ol[$];

  chan_pkt_framer dut (
    .ce_clk(ce_clk), .ce_rst_n(ce_rst_n), .pkt_words(pkt_words), .flush_req(flush_req),
    .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .pkt_count(pkt_count)
  );

  always #5 ce_clk = ~ce_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [USER_W-1:0] mk(input logic e, input int s, input int b);
    logic [USER_W-1:0] u;
    u = (USER_W'(e) << EOB_BIT) | (USER_W'(s) << SEQ_LSB) | (USER_W'(b) << BIN_LSB);
    return u;
  endfunction

  // downstream ready: 1-on/2-off pattern under backpressure, else held by stall
  always @(posedge ce_clk) begin
    #1;
    m_axis_tready = bp_on ? (ph == 0) : !stall;
    ph = ph == 2 ? 0 : ph + 1;
  end

  // handshake monitor and capture of every emitted word
  always @(posedge ce_clk) begin
    if (!ce_rst_n) begin
      acc = 0;
      emit = 0;
      od.delete();
      ou.delete();
      ol.delete();
    end else begin
      if (s_axis_tvalid && s_axis_tready) acc++;
      if (m_axis_tvalid && m_axis_tready) begin
        od.push_back(m_axis_tdata);
        ou.push_back(m_axis_tuser);
        ol.push_back(m_axis_tlast);
        emit++;
      end
    end
  end

  // stall stability and input blocking while H and O are both full
  always @(negedge ce_clk) begin
    if (ce_rst_n && chk_stab) begin
      if (was_stall) begin
        check("stall_tdata", m_axis_tdata, pd);
        check("stall_tuser", m_axis_tuser, pu);
      end
      if (m_axis_tvalid && !m_axis_tready && acc - emit >= 2) check("s_ready_blocked", s_axis_tready, 0);
      was_stall = m_axis_tvalid && !m_axis_tready;
      pd = m_axis_tdata;
      pu = m_axis_tuser;
    end else begin
      was_stall = 1'b0;
    end
  end

  task automatic send(input logic [DATA_W-1:0] d, input int b, input logic f);
    int n = 0;
    @(negedge ce_clk);
    while (!s_axis_tready && n < 200) begin
      @(negedge ce_clk);
      n++;
    end
    if (n >= 200) check("send_timeout", n, 0);
    s_axis_tvalid = 1'b1;
    s_axis_tdata = d;
    s_axis_tuser = BIN_W'(b);
    flush_req = f;
    @(posedge ce_clk);
    #1;
    s_axis_tvalid = 1'b0;
    flush_req = 1'b0;
  endtask

  task automatic flush();
    @(negedge ce_clk);
    flush_req = 1'b1;
    @(posedge ce_clk);
    #1;
    flush_req = 1'b0;
  endtask

  task automatic drain(input int left);
    int n = 0;
    @(negedge ce_clk);
    while (!(acc - emit == left && !m_axis_tvalid) && n < 500) begin
      @(negedge ce_clk);
      n++;
    end
    if (n >= 500) check("drain_timeout", n, 0);
  endtask

  task automatic do_reset();
    @(negedge ce_clk);
    ce_rst_n = 1'b0;
    repeat (2) @(negedge ce_clk);
    ce_rst_n = 1'b1;
  endtask

  task automatic expw(input int i, input logic [DATA_W-1:0] d, input int b, input int s,
                      input logic l, input logic e);
    if (i >= od.size()) check("word_present", od.size(), i + 1);
    else begin
      check($sformatf("tdata[%0d]", i), od[i], d);
      check($sformatf("tuser[%0d]", i), ou[i], mk(e, s, b));
      check($sformatf("tlast[%0d]", i), ol[i], l);
    end
  endtask

  initial begin
    repeat (3) @(negedge ce_clk);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_tuser", m_axis_tuser, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_pkt_count", pkt_count, 0);
    ce_rst_n = 1'b1;

    // ten words on one bin, length 4, then flush
    pkt_words = 16'd4;
    for (int i = 0; i < 10; i++) send(32'hA000 + i, 5, 1'b0);
    flush();
    drain(0);
    check("a_words", od.size(), 10);
    for (int i = 0; i < 10; i++) expw(i, 32'hA000 + i, 5, i / 4, (i % 4 == 3) || i == 9, i == 9);
    check("a_pkt_count", pkt_count, 3);

    // bin change closes the packet early
    do_reset();
    pkt_words = 16'd16;
    send(32'hB0, 3, 1'b0);
    send(32'hB1, 3, 1'b0);
    send(32'hB2, 3, 1'b0);
    send(32'hB3, 7, 1'b0);
    send(32'hB4, 7, 1'b0);
    flush();
    drain(0);
    check("b_words", od.size(), 5);
    for (int i = 0; i < 3; i++) expw(i, 32'hB0 + i, 3, 0, i == 2, 1'b0);
    for (int i = 3; i < 5; i++) expw(i, 32'hB0 + i, 7, 1, i == 4, i == 4);
    check("b_pkt_count", pkt_count, 2);

    // 100-word stream under 1-on/2-off backpressure
    do_reset();
    pkt_words = 16'd8;
    @(negedge ce_clk);
    bp_on = 1'b1;
    chk_stab = 1'b1;
    for (int i = 0; i < 100; i++) send(32'h100 + i, 1, 1'b0);
    flush();
    drain(0);
    chk_stab = 1'b0;
    bp_on = 1'b0;
    check("c_words", od.size(), 100);
    for (int i = 0; i < 100; i++) expw(i, 32'h100 + i, 1, i / 8, (i % 8 == 7) || i == 99, i == 99);
    check("c_pkt_count", pkt_count, 13);

    // flush in the same cycle as the third word
    do_reset();
    pkt_words = 16'd8;
    send(32'hD0, 6, 1'b0);
    send(32'hD1, 6, 1'b0);
    send(32'hD2, 6, 1'b1);
    @(negedge ce_clk);
    check("d_ready_during_flush", s_axis_tready, 0);
    drain(0);
    check("d_words", od.size(), 3);
    expw(0, 32'hD0, 6, 0, 1'b0, 1'b0);
    expw(1, 32'hD1, 6, 0, 1'b0, 1'b0);
    expw(2, 32'hD2, 6, 0, 1'b1, 1'b1);
    check("d_pkt_count", pkt_count, 1);
    check("d_ready_after", s_axis_tready, 1);

    // zero length: every word is its own packet, seq wraps
    do_reset();
    pkt_words = 16'd0;
    for (int i = 0; i < 4098; i++) send(DATA_W'(i), 2, 1'b0);
    drain(1);
    check("e_words", od.size(), 4097);
    begin
      int nl = 0;
      foreach (ol[i]) if (ol[i] !== 1'b1) nl++;
      check("e_nonlast", nl, 0);
    end
    expw(0, 32'd0, 2, 0, 1'b1, 1'b0);
    expw(4095, 32'd4095, 2, 4095, 1'b1, 1'b0);
    expw(4096, 32'd4096, 2, 0, 1'b1, 1'b0);
    check("e_pkt_count", pkt_count, 4097);

    // asynchronous reset with H and O both full
    do_reset();
    pkt_words = 16'd8;
    stall = 1'b1;
    send(32'hF0, 9, 1'b0);
    send(32'hF1, 9, 1'b0);
    @(negedge ce_clk);
    check("f_o_valid_pre", m_axis_tvalid, 1);
    check("f_s_ready_pre", s_axis_tready, 0);
    #2;
    ce_rst_n = 1'b0;
    #1;
    check("f_async_tvalid", m_axis_tvalid, 0);
    check("f_async_pkt_count", pkt_count, 0);
    repeat (2) @(negedge ce_clk);
    ce_rst_n = 1'b1;
    stall = 1'b0;
    pkt_words = 16'd2;
    send(32'hC0, 4, 1'b0);
    send(32'hC1, 4, 1'b0);
    send(32'hC2, 4, 1'b0);
    flush();
    drain(0);
    check("f_words", od.size(), 3);
    expw(0, 32'hC0, 4, 0, 1'b0, 1'b0);
    expw(1, 32'hC1, 4, 0, 1'b1, 1'b0);
    expw(2, 32'hC2, 4, 1, 1'b1, 1'b1);
    check("f_pkt_count", pkt_count, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
